secuenciador_muestreo: RTL and testbench

Sampling controller for the temperature-monitoring datapath. It periodically requests a conversion from the external temperature sensor/ADC, waits for the data-ready response with a timeout, averages 2^PROM_LOG2 consecutive 5-bit samples, and presents a registered average with a one-cycle valid pulse. It sits between the sensor pins and the downstream BCD/decision/display logic. It replaces direct use of the raw temperature bus and data-ready line.

---
 rtl/sensor_pkg.sv | 15 +
 rtl/secuenciador_muestreo_if.sv | 25 ++
 rtl/divisor_muestreo.sv | 30 +++
 rtl/secuenciador_muestreo.sv | 137 +++++++++++++
 tb/tb_secuenciador_muestreo.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/sensor_pkg.sv
// Shared constants for the temperature path: sample width and controller state codes.
// Downstream control/display logic decodes estado with these same values.
package sensor_pkg;

   localparam int unsigned TEMP_W   = 5;
   localparam int unsigned ESTADO_W = 2;

   typedef enum logic [ESTADO_W-1:0] {
      REPOSO      = 2'b00,
      INICIAR     = 2'b01,
      ESPERAR_ADC = 2'b10,
      PROMEDIAR   = 2'b11
   } estado_t;

endpackage

// File: rtl/secuenciador_muestreo_if.sv
// Sensor-side and result-side signals of the sampling controller.
// master = controller, slave = sensor pins plus downstream consumers.
interface secuenciador_muestreo_if;
   import sensor_pkg::*;

   logic              habilitar;
   logic              adc_listo;
   logic [TEMP_W-1:0] temperatura_adc;
   logic              iniciar_conv;
   logic [TEMP_W-1:0] temperatura;
   logic              dato_valido;
   logic              error_sensor;
   estado_t           estado;

   modport master (
      input  habilitar, adc_listo, temperatura_adc,
      output iniciar_conv, temperatura, dato_valido, error_sensor, estado
   );

   modport slave (
      output habilitar, adc_listo, temperatura_adc,
      input  iniciar_conv, temperatura, dato_valido, error_sensor, estado
   );

endinterface

// File: rtl/divisor_muestreo.sv
// Free-running interval counter 0..PERIODO-1; tick is high during the terminal-count cycle.
// Cleared synchronously while habilitar is low. Also reused for the display refresh clock.
module divisor_muestreo #(
   parameter int unsigned PERIODO = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic habilitar,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(PERIODO);

   logic [CNT_W-1:0] cnt;

   // tick is registered one count early so it lines up with cnt == PERIODO-1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (!habilitar) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= (cnt == CNT_W'(PERIODO - 1)) ? '0 : cnt + CNT_W'(1);
         tick <= (cnt == CNT_W'(PERIODO - 2));
      end
   end

endmodule

// File: rtl/secuenciador_muestreo.sv
// Sampling controller: periodic conversion request, ADC handshake with timeout,
// averaging of 2^PROM_LOG2 samples and registered result with a valid pulse.
module secuenciador_muestreo
   import sensor_pkg::*;
#(
   parameter int unsigned PERIODO   = 1_000_000,
   parameter int unsigned TIMEOUT   = 1000,
   parameter int unsigned PROM_LOG2 = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   secuenciador_muestreo_if.master bus
);

   localparam int unsigned ACC_W        = TEMP_W + PROM_LOG2;
   localparam int unsigned NUM_W        = PROM_LOG2 + 1;
   localparam int unsigned TO_W         = $clog2(TIMEOUT);
   localparam int unsigned NUM_MUESTRAS = 1 << PROM_LOG2;

   estado_t           estado_q, estado_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [NUM_W-1:0]  num_q, num_d;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic              adc_prev_q;
   logic              iniciar_q, iniciar_d;
   logic [TEMP_W-1:0] temp_q, temp_d;
   logic              valido_q, valido_d;
   logic              error_q, error_d;

   logic              tick;
   logic              flanco_c;
   logic              vencido_c;
   logic              ultima_c;
   logic [NUM_W-1:0]  num_inc_c;

   divisor_muestreo #(.PERIODO(PERIODO)) u_divisor (
      .clk       (clk),
      .rst       (rst),
      .habilitar (bus.habilitar),
      .tick      (tick)
   );

   assign flanco_c  = bus.adc_listo & ~adc_prev_q;
   assign vencido_c = (tcnt_q == TO_W'(TIMEOUT - 1));
   assign num_inc_c = num_q + NUM_W'(1);
   assign ultima_c  = (num_inc_c == NUM_W'(NUM_MUESTRAS));

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado_q   <= REPOSO;
         acc_q      <= '0;
         num_q      <= '0;
         tcnt_q     <= '0;
         adc_prev_q <= 1'b0;
         iniciar_q  <= 1'b0;
         temp_q     <= '0;
         valido_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         acc_q      <= acc_d;
         num_q      <= num_d;
         tcnt_q     <= tcnt_d;
         adc_prev_q <= bus.adc_listo;
         iniciar_q  <= iniciar_d;
         temp_q     <= temp_d;
         valido_q   <= valido_d;
         error_q    <= error_d;
      end
   end

   // Next state; a low habilitar aborts from any state, and ticks outside REPOSO are dropped
   always_comb begin
      estado_d = estado_q;
      if (!bus.habilitar) begin
         estado_d = REPOSO;
      end else begin
         case (estado_q)
            REPOSO:      if (tick) estado_d = INICIAR;
            INICIAR:     estado_d = ESPERAR_ADC;
            ESPERAR_ADC: begin
               if (flanco_c)       estado_d = ultima_c ? PROMEDIAR : REPOSO;
               else if (vencido_c) estado_d = REPOSO;
            end
            PROMEDIAR:   estado_d = REPOSO;
            default:     estado_d = REPOSO;
         endcase
      end
   end

   // Output and datapath next values; an edge wins over a simultaneous timeout
   always_comb begin
      acc_d     = acc_q;
      num_d     = num_q;
      tcnt_d    = tcnt_q;
      temp_d    = temp_q;
      error_d   = error_q;
      valido_d  = 1'b0;
      iniciar_d = (estado_d == INICIAR);
      if (!bus.habilitar) begin
         acc_d = '0;
         num_d = '0;
      end else begin
         case (estado_q)
            INICIAR: tcnt_d = '0;
            ESPERAR_ADC: begin
               if (flanco_c) begin
                  acc_d = acc_q + ACC_W'(bus.temperatura_adc);
                  num_d = num_inc_c;
               end else if (vencido_c) begin
                  error_d = 1'b1;
                  acc_d   = '0;
                  num_d   = '0;
               end else begin
                  tcnt_d = tcnt_q + TO_W'(1);
               end
            end
            PROMEDIAR: begin
               temp_d   = TEMP_W'(acc_q >> PROM_LOG2);
               valido_d = 1'b1;
               error_d  = 1'b0;
               acc_d    = '0;
               num_d    = '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.iniciar_conv = iniciar_q;
   assign bus.temperatura  = temp_q;
   assign bus.dato_valido  = valido_q;
   assign bus.error_sensor = error_q;
   assign bus.estado       = estado_q;

endmodule

// File: tb/tb_secuenciador_muestreo.sv
// Bench for secuenciador_muestreo with PERIODO=8, TIMEOUT=5, PROM_LOG2=2.
// Each request window of 8 cycles is predicted from the response delay chosen for it.
module tb_secuenciador_muestreo;
   import sensor_pkg::*;

   localparam int unsigned PERIODO   = 8;
   localparam int unsigned TIMEOUT   = 5;
   localparam int unsigned PROM_LOG2 = 2;
   localparam int unsigned N_PROM    = 1 << PROM_LOG2;

   logic clk;
   logic rst;

   secuenciador_muestreo_if bus ();

   secuenciador_muestreo #(
      .PERIODO   (PERIODO),
      .TIMEOUT   (TIMEOUT),
      .PROM_LOG2 (PROM_LOG2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   int   cola[$];
   logic [7:0] exp_temp = '0;
   logic       exp_err  = 1'b0;
   logic       nivel    = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_salidas(input string tag, input logic [7:0] st, input logic ini, input logic val);
      check({tag, ".estado"},       8'(bus.estado),       st);
      check({tag, ".iniciar_conv"}, 8'(bus.iniciar_conv), 8'(ini));
      check({tag, ".dato_valido"},  8'(bus.dato_valido),  8'(val));
      check({tag, ".temperatura"},  8'(bus.temperatura),  exp_temp);
      check({tag, ".error_sensor"}, 8'(bus.error_sensor), 8'(exp_err));
   endtask

   // One request window: the sensor answers with a rising edge d cycles after the
   // request (d=0: never). Edges 1..TIMEOUT cycles after the request are accepted.
   task automatic do_round(input int d, input logic [4:0] s, input bit fijar);
      bit   acepta;
      bit   ultima;
      int   suma;
      logic [7:0] st;
      acepta = (d >= 1) && (d <= int'(TIMEOUT));
      ultima = acepta && (cola.size() == int'(N_PROM) - 1);
      suma   = int'(s);
      foreach (cola[i]) suma += cola[i];
      step();
      check_salidas("peticion", 8'(INICIAR), 1'b1, 1'b0);
      for (int off = 1; off < int'(PERIODO); off++) begin
         step();
         if (acepta && off == d) cola.push_back(int'(s));
         if (!acepta && off == int'(TIMEOUT) + 1) begin
            exp_err = 1'b1;
            cola.delete();
         end
         if (ultima && off == d + 2) begin
            exp_temp = 8'(suma / int'(N_PROM));
            exp_err  = 1'b0;
            cola.delete();
         end
         if (acepta)
            st = (off <= d) ? 8'(ESPERAR_ADC) : (ultima && off == d + 1) ? 8'(PROMEDIAR) : 8'(REPOSO);
         else
            st = (off <= int'(TIMEOUT)) ? 8'(ESPERAR_ADC) : 8'(REPOSO);
         check_salidas($sformatf("ronda d=%0d off=%0d", d, off), st, 1'b0, ultima && off == d + 2);
         if (fijar && off == d) nivel = 1'b1;
         bus.adc_listo       = nivel || (off == d);
         bus.temperatura_adc = (off == d) ? s : 5'(off * 3);
      end
   endtask

   task automatic espera_inactiva(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check_salidas(tag, 8'(REPOSO), 1'b0, 1'b0);
      end
   endtask

   initial begin
      rst                 = 1'b0;
      bus.habilitar       = 1'b0;
      bus.adc_listo       = 1'b0;
      bus.temperatura_adc = '0;
      step();
      step();
      check_salidas("reset", 8'(REPOSO), 1'b0, 1'b0);
      rst = 1'b1;
      step();

      // First request PERIODO cycles after enabling, then 20..23 averages to 21
      bus.habilitar = 1'b1;
      espera_inactiva("arranque", int'(PERIODO) - 1);
      for (int i = 0; i < 4; i++) do_round(2, 5'(20 + i), 1'b0);

      // Missing response sets the error; a full good set of 31 clears it
      do_round(0, 5'd0, 1'b0);
      for (int i = 0; i < 4; i++) do_round(2, 5'd31, 1'b0);

      // Edge coinciding with the timeout is accepted
      do_round(int'(TIMEOUT), 5'd9, 1'b0);
      do_round(3, 5'd14, 1'b0);
      do_round(1, 5'd2, 1'b0);
      do_round(4, 5'd27, 1'b0);

      // Level held high across two requests: second one sees no edge
      do_round(2, 5'd17, 1'b1);
      do_round(0, 5'd0, 1'b0);
      nivel         = 1'b0;
      bus.adc_listo = 1'b0;

      // Abort after two samples; partial samples are discarded, outputs hold
      do_round(2, 5'd1, 1'b0);
      do_round(3, 5'd1, 1'b0);
      bus.habilitar = 1'b0;
      cola.delete();
      espera_inactiva("abortado", 12);
      bus.habilitar = 1'b1;
      espera_inactiva("rearranque", int'(PERIODO) - 1);
      do_round(2, 5'd12, 1'b0);
      do_round(5, 5'd13, 1'b0);
      do_round(1, 5'd14, 1'b0);
      do_round(3, 5'd16, 1'b0);

      // Randomized response delays (including late and missing) and samples
      for (int i = 0; i < 40; i++)
         do_round(int'($urandom_range(0, 6)), 5'($urandom_range(0, 31)), 1'b0);

      // Asynchronous reset while waiting for the ADC
      step();
      check_salidas("pre_reset", 8'(INICIAR), 1'b1, 1'b0);
      step();
      step();
      check({"pre_reset.estado"}, 8'(bus.estado), 8'(ESPERAR_ADC));
      #2 rst = 1'b0;
      #1;
      exp_temp = '0;
      exp_err  = 1'b0;
      cola.delete();
      check_salidas("reset_async", 8'(REPOSO), 1'b0, 1'b0);
      bus.habilitar = 1'b0;
      step();
      rst = 1'b1;
      espera_inactiva("tras_reset", 3);
      bus.habilitar = 1'b1;
      espera_inactiva("tras_reset_hab", int'(PERIODO) - 1);
      do_round(2, 5'd6, 1'b0);
      do_round(2, 5'd7, 1'b0);
      do_round(2, 5'd8, 1'b0);
      do_round(2, 5'd10, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
